// File: rtl/gte_seq_pkg.sv
// Shared constants and types for the GTE add-path command sequencer.
package gte_seq_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CV_W  = 2;
  localparam int unsigned PH_W  = 2;

  // Opcodes that have an add-path program
  localparam logic [OP_W-1:0] OP_RTPS  = 6'h01;
  localparam logic [OP_W-1:0] OP_DPCS  = 6'h10;
  localparam logic [OP_W-1:0] OP_MVMVA = 6'h12;
  localparam logic [OP_W-1:0] OP_NCDS  = 6'h13;
  localparam logic [OP_W-1:0] OP_AVSZ3 = 6'h2D;
  localparam logic [OP_W-1:0] OP_GPL   = 6'h3E;

  // Add-path operand selects
  localparam logic [SEL_W-1:0] SEL_TR   = 4'd0;
  localparam logic [SEL_W-1:0] SEL_BK   = 4'd1;
  localparam logic [SEL_W-1:0] SEL_FC   = 4'd2;
  localparam logic [SEL_W-1:0] SEL_ZERO = 4'd3;
  localparam logic [SEL_W-1:0] SEL_COL  = 4'd4;
  localparam logic [SEL_W-1:0] SEL_MAC  = 4'd5;
  localparam logic [SEL_W-1:0] SEL_ZSF  = 4'd6;
  localparam logic [SEL_W-1:0] SEL_TMP  = 4'd7;
  localparam logic [SEL_W-1:0] SEL_OF   = 4'd8;
  localparam logic [SEL_W-1:0] SEL_SPC  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Control word consumed by the add-path selector
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [ID_W-1:0]  id;
    logic             useSF;
    logic             isMVMVA;
    logic [CV_W-1:0]  cv;
  } gteSelAddCtrl;

endpackage

// File: rtl/gte_addpath_prog.sv
// Program table: (opcode, phase) -> add-path control for that phase.
module gte_addpath_prog
  import gte_seq_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [PH_W-1:0]  i_phase,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_useSF,
  output logic             o_isMVMVA,
  output logic             o_lastPhase,
  output logic             o_singleStep,
  output logic             o_valid
);

  // Phase lookup; unknown opcodes and out-of-range phases report invalid
  always_comb begin
    o_sel        = SEL_ZERO;
    o_useSF      = 1'b0;
    o_isMVMVA    = 1'b0;
    o_lastPhase  = 1'b0;
    o_singleStep = 1'b0;
    o_valid      = 1'b0;
    case (i_op)
      OP_MVMVA: if (i_phase == 2'd0) begin
        o_isMVMVA = 1'b1; o_lastPhase = 1'b1; o_valid = 1'b1;
      end
      OP_RTPS: case (i_phase)
        2'd0:    begin o_sel = SEL_TR; o_valid = 1'b1; end
        2'd1:    begin o_sel = SEL_OF; o_lastPhase = 1'b1; o_valid = 1'b1; end
        default: ;
      endcase
      OP_NCDS: case (i_phase)
        2'd0:    begin o_sel = SEL_BK;  o_valid = 1'b1; end
        2'd1:    begin o_sel = SEL_SPC; o_valid = 1'b1; end
        2'd2:    begin o_sel = SEL_FC;  o_lastPhase = 1'b1; o_valid = 1'b1; end
        default: ;
      endcase
      OP_DPCS: case (i_phase)
        2'd0:    begin o_sel = SEL_COL; o_valid = 1'b1; end
        2'd1:    begin o_sel = SEL_FC;  o_lastPhase = 1'b1; o_valid = 1'b1; end
        default: ;
      endcase
      OP_GPL: if (i_phase == 2'd0) begin
        o_sel = SEL_MAC; o_useSF = 1'b1; o_lastPhase = 1'b1; o_valid = 1'b1;
      end
      OP_AVSZ3: if (i_phase == 2'd0) begin
        o_sel = SEL_ZSF; o_lastPhase = 1'b1; o_singleStep = 1'b1; o_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gte_addpath_seq.sv
// GTE add-path command sequencer: steps the selector control word per opcode program.
module gte_addpath_seq
  import gte_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmdValid,
  input  logic [OP_W-1:0]  i_cmdOp,
  input  logic             i_sf,
  input  logic [CV_W-1:0]  i_cv,
  output logic             o_cmdReady,
  input  logic             i_stall,
  output logic [SEL_W-1:0] o_sel,
  output logic [ID_W-1:0]  o_id,
  output logic             o_useSF,
  output logic             o_isMVMVA,
  output logic [CV_W-1:0]  o_cv,
  output logic             o_stepValid,
  output logic             o_last,
  output logic             o_done,
  output logic             o_err
);

  seq_state_e       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             sf_q, sf_d;
  logic [CV_W-1:0]  cv_q, cv_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [ID_W-1:0]  id_q, id_d;
  gteSelAddCtrl     ctrl_q, ctrl_d;
  logic             step_valid_q, step_valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             accept_c;

  logic [SEL_W-1:0] p_sel;
  logic             p_use_sf, p_is_mvmva, p_last_phase, p_single, p_valid;

  assign accept_c = i_cmdValid & ready_q;

  // Program lookup for the phase that will be live next cycle
  gte_addpath_prog u_prog (
    .i_op         (op_d),
    .i_phase      (phase_d),
    .o_sel        (p_sel),
    .o_useSF      (p_use_sf),
    .o_isMVMVA    (p_is_mvmva),
    .o_lastPhase  (p_last_phase),
    .o_singleStep (p_single),
    .o_valid      (p_valid)
  );

  // Command latches and phase/id counters; stall simply holds everything
  always_comb begin
    op_d    = op_q;
    sf_d    = sf_q;
    cv_d    = cv_q;
    phase_d = phase_q;
    id_d    = id_q;
    if (accept_c) begin
      op_d    = i_cmdOp;
      sf_d    = i_sf;
      cv_d    = i_cv;
      phase_d = '0;
      id_d    = '0;
    end else if (state_q == ST_RUN && !i_stall && !last_q) begin
      if (id_q == ID_W'(2)) begin
        phase_d = phase_q + PH_W'(1);
        id_d    = '0;
      end else begin
        id_d = id_q + ID_W'(1);
      end
    end
  end

  // Next state and next registered control word
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    ctrl_d       = '{sel: SEL_ZERO, id: '0, useSF: 1'b0, isMVMVA: 1'b0, cv: cv_d};
    step_valid_d = 1'b0;
    last_d       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          state_d = p_valid ? ST_RUN : ST_DONE;
          done_d  = ~p_valid;
          err_d   = ~p_valid;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!i_stall && last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_RUN) begin
      ctrl_d.sel     = p_sel;
      ctrl_d.id      = id_d;
      ctrl_d.useSF   = p_use_sf & sf_d;
      ctrl_d.isMVMVA = p_is_mvmva;
      step_valid_d   = 1'b1;
      last_d         = p_last_phase & (p_single | (id_d == ID_W'(2)));
    end
    ready_d = (state_d != ST_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      sf_q         <= 1'b0;
      cv_q         <= '0;
      phase_q      <= '0;
      id_q         <= '0;
      ctrl_q       <= '{sel: SEL_ZERO, id: '0, useSF: 1'b0, isMVMVA: 1'b0, cv: '0};
      step_valid_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sf_q         <= sf_d;
      cv_q         <= cv_d;
      phase_q      <= phase_d;
      id_q         <= id_d;
      ctrl_q       <= ctrl_d;
      step_valid_q <= step_valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
    end
  end

  assign o_cmdReady  = ready_q;
  assign o_sel       = ctrl_q.sel;
  assign o_id        = ctrl_q.id;
  assign o_useSF     = ctrl_q.useSF;
  assign o_isMVMVA   = ctrl_q.isMVMVA;
  assign o_cv        = ctrl_q.cv;
  assign o_stepValid = step_valid_q;
  assign o_last      = last_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_gte_addpath_seq.sv
// Bench for gte_addpath_seq: directed scenarios plus random traffic against a step-list model.
module tb_gte_addpath_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cmdValid = 1'b0;
  logic [5:0] i_cmdOp = '0;
  logic       i_sf = 1'b0;
  logic [1:0] i_cv = '0;
  logic       i_stall = 1'b0;
  logic       o_cmdReady;
  logic [3:0] o_sel;
  logic [1:0] o_id;
  logic       o_useSF, o_isMVMVA;
  logic [1:0] o_cv;
  logic       o_stepValid, o_last, o_done, o_err;

  gte_addpath_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmdValid(i_cmdValid), .i_cmdOp(i_cmdOp),
    .i_sf(i_sf), .i_cv(i_cv), .o_cmdReady(o_cmdReady), .i_stall(i_stall),
    .o_sel(o_sel), .o_id(o_id), .o_useSF(o_useSF), .o_isMVMVA(o_isMVMVA),
    .o_cv(o_cv), .o_stepValid(o_stepValid), .o_last(o_last), .o_done(o_done),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] id;
    logic       usf;
    logic       mv;
  } step_t;

  // Model: the ordered list of steps the current command should show
  step_t steps[$];
  bit    run_m  = 1'b0;
  int    idx_m  = 0;
  bit    done_m = 1'b0;
  bit    err_m  = 1'b0;
  bit    rdy_m  = 1'b0;
  logic [1:0] cv_m = '0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic add_phase(input logic [3:0] sel, input logic usf, input logic mv, input int n);
    step_t s;
    for (int k = 0; k < n; k++) begin
      s.sel = sel; s.id = 2'(k); s.usf = usf; s.mv = mv;
      steps.push_back(s);
    end
  endtask

  task automatic build(input logic [5:0] op, input logic sf);
    steps.delete();
    case (op)
      6'h12: add_phase(4'd3, 1'b0, 1'b1, 3);
      6'h01: begin add_phase(4'd0, 1'b0, 1'b0, 3); add_phase(4'd8, 1'b0, 1'b0, 3); end
      6'h13: begin
        add_phase(4'd1, 1'b0, 1'b0, 3);
        add_phase(4'd9, 1'b0, 1'b0, 3);
        add_phase(4'd2, 1'b0, 1'b0, 3);
      end
      6'h10: begin add_phase(4'd4, 1'b0, 1'b0, 3); add_phase(4'd2, 1'b0, 1'b0, 3); end
      6'h3E: add_phase(4'd5, sf, 1'b0, 3);
      6'h2D: add_phase(4'd6, 1'b0, 1'b0, 1);
      default: ;
    endcase
  endtask

  // Called at a negedge: compare outputs, drive inputs for the next posedge, advance the model
  task automatic run_cycle(input logic v, input logic [5:0] op, input logic sf,
                           input logic [1:0] cv, input logic st, input logic r);
    step_t s;
    if (run_m) begin
      s = steps[idx_m];
      if (!s.mv) check_eq("sel", 32'(o_sel), 32'(s.sel));
      check_eq("id", 32'(o_id), 32'(s.id));
      check_eq("useSF", 32'(o_useSF), 32'(s.usf));
      check_eq("isMVMVA", 32'(o_isMVMVA), 32'(s.mv));
      check_eq("stepValid", 32'(o_stepValid), 32'd1);
      check_eq("last", 32'(o_last), 32'(idx_m == steps.size() - 1));
    end else begin
      check_eq("sel_idle", 32'(o_sel), 32'd3);
      check_eq("id_idle", 32'(o_id), 32'd0);
      check_eq("useSF_idle", 32'(o_useSF), 32'd0);
      check_eq("isMVMVA_idle", 32'(o_isMVMVA), 32'd0);
      check_eq("stepValid_idle", 32'(o_stepValid), 32'd0);
      check_eq("last_idle", 32'(o_last), 32'd0);
    end
    check_eq("done", 32'(o_done), 32'(done_m));
    check_eq("err", 32'(o_err), 32'(err_m));
    check_eq("cmdReady", 32'(o_cmdReady), 32'(rdy_m && !run_m));
    check_eq("cv", 32'(o_cv), 32'(cv_m));

    i_cmdValid = v; i_cmdOp = op; i_sf = sf; i_cv = cv; i_stall = st; i_rst = r;

    if (r) begin
      run_m = 1'b0; done_m = 1'b0; err_m = 1'b0; rdy_m = 1'b0; cv_m = '0;
    end else begin
      done_m = 1'b0; err_m = 1'b0;
      if (run_m) begin
        if (!st) begin
          if (idx_m == steps.size() - 1) begin
            run_m = 1'b0; done_m = 1'b1;
          end else begin
            idx_m++;
          end
        end
      end else if (v && rdy_m) begin
        cv_m = cv;
        build(op, sf);
        if (steps.size() == 0) begin
          done_m = 1'b1; err_m = 1'b1;
        end else begin
          run_m = 1'b1; idx_m = 0;
        end
      end
      rdy_m = 1'b1;
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  logic [5:0] ops[6];

  initial begin
    ops[0] = 6'h01; ops[1] = 6'h12; ops[2] = 6'h13;
    ops[3] = 6'h10; ops[4] = 6'h3E; ops[5] = 6'h2D;
    @(negedge i_clk);
    // Reset held, then released
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(2);
    // NCDS, no stall
    run_cycle(1'b1, 6'h13, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(11);
    // MVMVA with cv=2
    run_cycle(1'b1, 6'h12, 1'b0, 2'd2, 1'b0, 1'b0);
    idle(5);
    // GPL with sf=1, stall on the 2nd and 3rd sequence cycles
    run_cycle(1'b1, 6'h3E, 1'b1, 2'd1, 1'b0, 1'b0);
    run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(5);
    // Unknown opcode
    run_cycle(1'b1, 6'h00, 1'b0, 2'd3, 1'b0, 1'b0);
    idle(3);
    // DPCS then AVSZ3 accepted in DONE
    run_cycle(1'b1, 6'h10, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(6);
    run_cycle(1'b1, 6'h2D, 1'b0, 2'd1, 1'b0, 1'b0);
    idle(4);
    // RTPS abandoned by reset at its 4th step
    run_cycle(1'b1, 6'h01, 1'b0, 2'd2, 1'b0, 1'b0);
    idle(3);
    run_cycle(1'b0, 6'h00, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4);
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned k;
      logic [5:0] op;
      k  = $urandom_range(0, 6);
      op = (k == 6) ? 6'($urandom) : ops[k];
      run_cycle(($urandom % 3) != 0, op, 1'($urandom), 2'($urandom),
                ($urandom % 4) == 0, ($urandom % 200) == 0);
    end
    idle(12);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gte_addpath_seq.md
# gte_addpath_seq

Command sequencer for the GTE add-path selector. Accepts one GTE opcode at a time and, over successive cycles, drives the selector control fields `sel`, `id`, `useSF`, `isMVMVA` and `cv` so that the adder receives the correct 44-bit pre-shifted operand for each component step. It sits between the GTE command decoder and the add-path selector, and it frees the decoder from per-cycle operand scheduling.

## Interface
- No parameters.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_cmdValid` in 1: command request.
- `i_cmdOp` in 6: GTE opcode.
- `i_sf` in 1: shift-fraction flag of the command.
- `i_cv` in 2: MVMVA translation-vector select.
- `o_cmdReady` out 1: block can accept a command this cycle.
- `i_stall` in 1: datapath hold; freezes the sequence.
- `o_sel` out 4: add-path operand select.
- `o_id` out 2: component index (0=X/R, 1=Y/G, 2=Z/B).
- `o_useSF` out 1: apply `i_sf` to the MAC operand.
- `o_isMVMVA` out 1: selector uses `cv` instead of `sel`.
- `o_cv` out 2: latched `cv`.
- `o_stepValid` out 1: current control word is live.
- `o_last` out 1: current step is the final step.
- `o_done` out 1: one-cycle completion pulse.
- `o_err` out 1: one-cycle pulse for an opcode with no program.

## Operation
- **States:** IDLE, RUN, DONE.
- **Accept:** `i_cmdValid & o_cmdReady`. Latches the opcode, `i_sf` and `i_cv`. `o_cmdReady` is 1 in IDLE and DONE, and 0 in RUN and during reset.
- **Step structure:** a program is 1–3 phases. Each phase has 3 steps with `o_id` = 0,1,2, except AVSZ3, which has a single step with `id` 0.
- **Programs:**
  - MVMVA (0x12): 1 phase, `isMVMVA`=1, `sel` ignored. 3 steps.
  - RTPS (0x01): `sel` 0 (TR), then `sel` 8 (OF0/OF1/DQB). 6 steps.
  - NCDS (0x13): `sel` 1 (BK), then `sel` 9 (special), then `sel` 2 (FC). 9 steps.
  - DPCS (0x10): `sel` 4 (colour), then `sel` 2. 6 steps.
  - GPL (0x3E): `sel` 5, `useSF`=1. 3 steps.
  - AVSZ3 (0x2D): `sel` 6. 1 step.
- **Unknown opcode:** accepted, FSM goes to DONE directly with no steps. `o_err` and `o_done` pulse together.
- **Stall:** `i_stall`=1 in RUN holds the phase and id counters and all outputs unchanged. `i_stall` is ignored in IDLE and DONE.
- **Transitions:**
  - RUN advances to the next step when not stalled.
  - After the last step is issued unstalled, RUN goes to DONE.
  - DONE goes to IDLE, or directly to RUN if a new command is accepted in DONE.
- **Outputs outside RUN:** `sel`=3 (zero vector), `id`=0, `useSF`=0, `isMVMVA`=0, `stepValid`=0, `last`=0.
- **Reset values:** all outputs 0 except `o_sel`=3. State is IDLE.
- **Reset mid-command:** the command is abandoned. No `o_done` is produced, and reset values apply in the following cycle.

## Timing
- All outputs are registered.
- Accept in cycle N: first step visible in N+1. Step k is visible in N+1+k plus accumulated stall cycles.
- `o_done` is asserted the cycle after the last step. A command accepted in DONE has its first step in the next cycle, so there is 1 bubble cycle between commands.
- **Unknown opcode:** accept in N gives `o_done`/`o_err` in N+1.
- `o_last` is coincident with the last step's `o_stepValid`.

## Structure
- Package `gte_seq_pkg`:
  - Opcode constants: `OP_RTPS`, `OP_MVMVA`, `OP_NCDS`, `OP_DPCS`, `OP_GPL`, `OP_AVSZ3`.
  - Select constants: `SEL_TR`=0, `SEL_BK`=1, `SEL_FC`=2, `SEL_ZERO`=3, `SEL_COL`=4, `SEL_MAC`=5, `SEL_ZSF`=6, `SEL_TMP`=7, `SEL_OF`=8, `SEL_SPC`=9.
  - FSM state enum.
- The `gteSelAddCtrl` struct is shared with the selector through `GTEDefine.hv`. The block's outputs map 1:1 onto its fields.
- Sub-module `gte_addpath_prog`: combinational, (opcode, phase) → {`sel`, `useSF`, `isMVMVA`, `lastPhase`, `singleStep`, `valid`}. The FSM, counters and latches stay in the top module.

## Test plan
- NCDS accepted at cycle 10, no stall → `sel`/`id` 1/0,1/1,1/2,9/0,9/1,9/2,2/0,2/1,2/2 in cycles 11–19; `o_last` at 19; `o_done` at 20.
- MVMVA with `cv`=2 → `isMVMVA`=1 and `o_cv`=2 for 3 steps with `id` 0..2; `o_sel`=3 is not used by the selector.
- GPL with `i_sf`=1 and `i_stall` high at cycles 2–3 of the sequence → step `id`=1 held for 3 cycles; `o_done` delayed by 2 cycles; `useSF`=1 throughout.
- Opcode 0x00 → no `o_stepValid`; `o_done` and `o_err` pulse together at N+1.
- AVSZ3 accepted in DONE of the previous DPCS → single step `sel`=6 `id`=0 at the next cycle; `o_cmdReady` is 0 during that step.
- `i_rst` asserted at step 4 of RTPS → next cycle `o_sel`=3, `o_stepValid`=0, no `o_done`; `o_cmdReady` returns to 1 after reset release.
